// File: rtl/adder_pkg.sv
// ============================================================================
//  Module      : adder_pkg
//  Description : Shared state encodings and default width for serial_adder.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package adder_pkg;

    // Default operand/result width in bits
    localparam int DEFAULT_WIDTH = 8;

    // Controller states; encoding 2'b11 is unused and recovers to IDLE
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_t;

endpackage : adder_pkg

`default_nettype wire

// File: rtl/full_adder.sv
// ============================================================================
//  Module      : full_adder
//  Description : One-bit combinational full adder.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module full_adder (
    input  logic i_a,
    input  logic i_b,
    input  logic i_cin,
    output logic o_s,
    output logic o_cout
);

    // Sum is the parity of the three inputs; carry is their majority
    always_comb begin
        o_s    = i_a ^ i_b ^ i_cin;
        o_cout = (i_a & i_b) | (i_a & i_cin) | (i_b & i_cin);
    end

endmodule : full_adder

`default_nettype wire

// File: rtl/serial_adder.sv
// ============================================================================
//  Module      : serial_adder
//  Description : Bit-serial adder, LSB first, one bit per clock. Result and
//                carry-out are registered and only update on completion.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_cin,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_cout
);

    // Counter only needs to reach WIDTH-1
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] C_LAST = CW'(WIDTH - 1);

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-2:0] r_psum;     // bits already computed, MSB-aligned
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;
    logic             r_cout;
    logic [CW-1:0]    r_cnt;
    logic             w_s;
    logic             w_c;
    logic             w_last;
    logic [WIDTH-1:0] w_psum_next;

    full_adder u_full_adder (
        .i_a    (r_a[0]),
        .i_b    (r_b[0]),
        .i_cin  (r_carry),
        .o_s    (w_s),
        .o_cout (w_c)
    );

    // New bit enters at the MSB; after WIDTH shifts this is the full sum
    always_comb begin
        w_last      = (r_cnt == C_LAST);
        w_psum_next = {w_s, r_psum};
    end

    // Next-state decode and status outputs
    always_comb begin
        w_next = ST_IDLE;
        o_busy = 1'b0;
        o_done = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_next = i_start ? ST_SHIFT : ST_IDLE;
            end
            ST_SHIFT: begin
                o_busy = 1'b1;
                w_next = w_last ? ST_DONE : ST_SHIFT;
            end
            ST_DONE: begin
                o_busy = 1'b1;
                o_done = 1'b1;
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Operand capture, bit-serial datapath and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_psum  <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_a     <= i_a;
                        r_b     <= i_b;
                        r_carry <= i_cin;
                        r_cnt   <= '0;
                    end
                end
                ST_SHIFT: begin
                    r_a     <= {1'b0, r_a[WIDTH-1:1]};
                    r_b     <= {1'b0, r_b[WIDTH-1:1]};
                    r_psum  <= w_psum_next[WIDTH-1:1];
                    r_carry <= w_c;
                    if (w_last) begin
                        r_sum  <= w_psum_next;
                        r_cout <= w_c;
                    end else begin
                        r_cnt  <= r_cnt + CW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign o_sum  = r_sum;
    assign o_cout = r_cout;

endmodule : serial_adder

`default_nettype wire

// File: tb/tb_serial_adder.sv
// ============================================================================
//  Module      : tb_serial_adder
//  Description : Self-checking bench for serial_adder (WIDTH = 8).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_adder;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         i_start;
    logic [W-1:0] i_a;
    logic [W-1:0] i_b;
    logic         i_cin;
    logic         o_busy;
    logic         o_done;
    logic [W-1:0] o_sum;
    logic         o_cout;

    int n_chk = 0;
    int n_bad = 0;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] exp_sum;
        logic         exp_cout;
    } vec_t;

    vec_t vecs[11];

    serial_adder #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .i_start (i_start),
        .i_a     (i_a),
        .i_b     (i_b),
        .i_cin   (i_cin),
        .o_busy  (o_busy),
        .o_done  (o_done),
        .o_sum   (o_sum),
        .o_cout  (o_cout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int unsigned act, input int unsigned exp);
        n_chk++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Caller must be at a negedge with the DUT in IDLE. Returns at the negedge
    // where done is visible (lat = negedge index, 0 on timeout).
    task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tc,
                         output logic [W-1:0] rs, output logic rc,
                         output int lat, output int busy_cnt, output int hold_bad);
        logic [W-1:0] prev_sum;
        logic         prev_cout;
        prev_sum  = o_sum;
        prev_cout = o_cout;
        rs = '0; rc = 1'b0; lat = 0; busy_cnt = 0; hold_bad = 0;
        i_a = ta; i_b = tb_v; i_cin = tc; i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        // Scramble inputs: the operation in flight must not see them
        i_a = ~ta; i_b = W'($urandom); i_cin = ~tc;
        for (int k = 1; k <= 40; k++) begin
            if (o_busy) busy_cnt++;
            if (o_done) begin
                lat = k; rs = o_sum; rc = o_cout;
                break;
            end
            if (o_sum !== prev_sum || o_cout !== prev_cout) hold_bad++;
            @(negedge clk);
        end
    endtask

    initial begin
        logic [W-1:0] rs, ra, rb;
        logic         rc, rcin;
        logic [W:0]   exp9;
        int           lat, bcnt, hbad, ndone, last_k;
        logic [W-1:0] dsum;
        logic         dcout;

        vecs[0]  = '{8'h5A, 8'h33, 1'b0, 8'h8D, 1'b0};
        vecs[1]  = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
        vecs[2]  = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
        vecs[3]  = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
        vecs[4]  = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0};
        vecs[5]  = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
        vecs[6]  = '{8'h0F, 8'hF1, 1'b0, 8'h00, 1'b1};
        vecs[7]  = '{8'hAA, 8'h55, 1'b1, 8'h00, 1'b1};
        vecs[8]  = '{8'hAA, 8'h55, 1'b0, 8'hFF, 1'b0};
        vecs[9]  = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0};
        vecs[10] = '{8'h12, 8'h34, 1'b1, 8'h47, 1'b0};

        // Reset with start asserted: reset must win
        rst = 1'b1; i_start = 1'b1; i_a = 8'hFF; i_b = 8'hFF; i_cin = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_busy", o_busy, 0);
        chk("reset_done", o_done, 0);
        chk("reset_sum",  o_sum,  0);
        chk("reset_cout", o_cout, 0);
        i_start = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        chk("idle_busy", o_busy, 0);

        // Directed vector table
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            do_op(vecs[i].a, vecs[i].b, vecs[i].cin, rs, rc, lat, bcnt, hbad);
            chk($sformatf("vec%0d_sum", i), rs, vecs[i].exp_sum);
            chk($sformatf("vec%0d_cout", i), rc, vecs[i].exp_cout);
            chk($sformatf("vec%0d_latency", i), lat, W + 1);
            chk($sformatf("vec%0d_busy_cycles", i), bcnt, W + 1);
            chk($sformatf("vec%0d_sum_hold", i), hbad, 0);
        end

        // start pulsed mid-operation must be ignored
        @(negedge clk);
        i_a = 8'h5A; i_b = 8'h33; i_cin = 1'b0; i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        repeat (2) @(negedge clk);
        i_a = 8'hFF; i_b = 8'hFF; i_cin = 1'b1; i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        ndone = 0; dsum = '0; dcout = 1'b1;
        for (int k = 0; k < 30; k++) begin
            if (o_done) begin ndone++; dsum = o_sum; dcout = o_cout; end
            @(negedge clk);
        end
        chk("midstart_ndone", ndone, 1);
        chk("midstart_sum", dsum, 8'h8D);
        chk("midstart_cout", dcout, 0);

        // Reset 4 cycles into an operation aborts it without a done pulse
        i_a = 8'h11; i_b = 8'h22; i_cin = 1'b0; i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        repeat (3) @(negedge clk);
        chk("abort_busy_before", o_busy, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_busy", o_busy, 0);
        chk("abort_sum",  o_sum,  0);
        chk("abort_cout", o_cout, 0);
        chk("abort_done", o_done, 0);
        rst = 1'b0;
        // start in the very first cycle after reset deasserts
        do_op(8'h0F, 8'h01, 1'b0, rs, rc, lat, bcnt, hbad);
        chk("post_rst_sum", rs, 8'h10);
        chk("post_rst_cout", rc, 0);
        chk("post_rst_latency", lat, W + 1);

        // Start held high: done every WIDTH+2 cycles
        @(negedge clk);
        i_a = 8'h01; i_b = 8'h02; i_cin = 1'b0; i_start = 1'b1;
        ndone = 0; last_k = 0;
        for (int k = 1; k <= 44; k++) begin
            @(negedge clk);
            if (o_done) begin
                ndone++;
                chk("b2b_sum", o_sum, 8'h03);
                if (last_k != 0) chk("b2b_period", k - last_k, W + 2);
                else chk("b2b_first", k, W + 1);
                last_k = k;
            end
        end
        chk("b2b_ndone", ndone, 4);
        i_start = 1'b0;
        repeat (20) @(negedge clk);
        chk("b2b_idle", o_busy, 0);
        chk("b2b_sum_hold", o_sum, 8'h03);

        // Randomised operations against a+b+cin
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            ra = W'($urandom); rb = W'($urandom); rcin = 1'($urandom);
            exp9 = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rcin};
            do_op(ra, rb, rcin, rs, rc, lat, bcnt, hbad);
            chk("rand_result", {rc, rs}, exp9);
            chk("rand_latency", lat, W + 1);
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule : tb_serial_adder

`default_nettype wire
